// File: rtl/issue_queue_2writer_if.sv
// Handshake bundle for issue_queue_2writer: two in-order enqueue lanes,
// one valid/ready dequeue lane and the occupancy count.
interface issue_queue_2writer_if #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
);
  logic                     in0_valid;
  logic [WIDTH-1:0]         in0_data;
  logic                     in1_valid;
  logic [WIDTH-1:0]         in1_data;
  logic                     in0_ready;
  logic                     in1_ready;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, count
  );

  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/issue_queue_2writer.sv
// Two-lane-in, one-lane-out in-order FIFO between dispatch and a single issue port.
// Optional head bypass for an empty queue: define ISSUE_QUEUE_2WRITER_BYPASS_EN.
module issue_queue_2writer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input logic                  sys_clk,
  input logic                  sys_rst_n,
  issue_queue_2writer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    head_r;
  logic [PW-1:0]    tail_r;
  logic [CW-1:0]    count_r;

  logic             in0_ready_s;
  logic             in1_ready_s;
  logic             out_valid_s;
  logic [WIDTH-1:0] out_data_s;
  logic             acc0_s;
  logic             acc1_s;
  logic             pop_s;
  logic             byp_take_s;
  logic             we0_s;
  logic             we1_s;
  logic             head_adv_s;
  logic [PW-1:0]    addr0_s;
  logic [PW-1:0]    addr1_s;
  logic [PW-1:0]    tail_next_s;
  logic [PW-1:0]    head_next_s;
  logic [CW-1:0]    count_next_s;

  // Lane readiness from registered occupancy; head view of the queue.
  always_comb begin
    in0_ready_s = (count_r <= CW'(DEPTH - 1));
    in1_ready_s = (count_r <= CW'(DEPTH - 2));
`ifdef ISSUE_QUEUE_2WRITER_BYPASS_EN
    if ((count_r == {CW{1'b0}}) && bus.in0_valid) begin
      out_valid_s = 1'b1;
      out_data_s  = bus.in0_data;
    end else begin
      out_valid_s = (count_r != {CW{1'b0}});
      out_data_s  = mem_r[head_r];
    end
`else
    out_valid_s = (count_r != {CW{1'b0}});
    out_data_s  = mem_r[head_r];
`endif
  end

  // Accept/pop decisions, write addressing and next pointer/occupancy values.
  always_comb begin
    acc0_s = bus.in0_valid & in0_ready_s;
    acc1_s = bus.in1_valid & in1_ready_s & acc0_s;
    pop_s  = out_valid_s & bus.out_ready;
`ifdef ISSUE_QUEUE_2WRITER_BYPASS_EN
    byp_take_s = (count_r == {CW{1'b0}}) & bus.in0_valid & bus.out_ready;
`else
    byp_take_s = 1'b0;
`endif
    // A bypassed lane-0 entry never lands in storage, so lane 1 takes its slot.
    we0_s      = acc0_s & ~byp_take_s;
    we1_s      = acc1_s;
    head_adv_s = pop_s & ~byp_take_s;
    addr0_s    = tail_r;
    if (byp_take_s) begin
      addr1_s = tail_r;
    end else begin
      addr1_s = tail_r + PW'(1'b1);
    end
    tail_next_s = tail_r + PW'(we0_s) + PW'(we1_s);
    if (head_adv_s) begin
      head_next_s = head_r + PW'(1'b1);
    end else begin
      head_next_s = head_r;
    end
    count_next_s = count_r + CW'(we0_s) + CW'(we1_s) - CW'(head_adv_s);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      head_r  <= head_next_s;
      tail_r  <= tail_next_s;
      count_r <= count_next_s;
    end
  end

  // Entry storage; contents are deliberately left untouched by reset.
  always_ff @(posedge sys_clk) begin
    if (we0_s) begin
      mem_r[addr0_s] <= bus.in0_data;
    end
    if (we1_s) begin
      mem_r[addr1_s] <= bus.in1_data;
    end
  end

  assign bus.in0_ready = in0_ready_s;
  assign bus.in1_ready = in1_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = out_data_s;
  assign bus.count     = count_r;
endmodule

// File: tb/tb_issue_queue_2writer.sv
// Randomized and directed bench for issue_queue_2writer against a queue-based
// reference model of the FIFO's accept/drain rules.
module tb_issue_queue_2writer;
  localparam int DEPTH = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic sys_rst_n;

  issue_queue_2writer_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  issue_queue_2writer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .sys_clk   (clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] mq[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every visible output against the model state plus current inputs.
  task automatic check_outputs();
    int sz;
    logic ev;
    logic [WIDTH-1:0] ed;
    sz = mq.size();
    ev = (sz != 0);
    ed = '0;
    if (sz != 0) ed = mq[0];
`ifdef ISSUE_QUEUE_2WRITER_BYPASS_EN
    if (sz == 0 && bus.in0_valid) begin
      ev = 1'b1;
      ed = bus.in0_data;
    end
`endif
    check("count", 32'(bus.count), 32'(sz));
    check("in0_ready", 32'(bus.in0_ready), 32'(sz <= DEPTH - 1));
    check("in1_ready", 32'(bus.in1_ready), 32'(sz <= DEPTH - 2));
    check("out_valid", 32'(bus.out_valid), 32'(ev));
    if (ev) check("out_data", 32'(bus.out_data), 32'(ed));
  endtask

  task automatic model_edge(input bit v0, input logic [WIDTH-1:0] d0,
                            input bit v1, input logic [WIDTH-1:0] d1, input bit ordy);
    int sz;
    bit a0, a1, byp;
    sz  = mq.size();
    a0  = v0 && (sz <= DEPTH - 1);
    a1  = v1 && (sz <= DEPTH - 2) && a0;
    byp = 1'b0;
`ifdef ISSUE_QUEUE_2WRITER_BYPASS_EN
    byp = (sz == 0) && v0 && ordy;
`endif
    if (byp) begin
      if (a1) mq.push_back(d1);
    end else begin
      if (sz != 0 && ordy) void'(mq.pop_front());
      if (a0) mq.push_back(d0);
      if (a1) mq.push_back(d1);
    end
  endtask

  task automatic cycle(input bit v0, input logic [WIDTH-1:0] d0,
                       input bit v1, input logic [WIDTH-1:0] d1, input bit ordy);
    @(negedge clk);
    bus.in0_valid = v0;
    bus.in0_data  = d0;
    bus.in1_valid = v1;
    bus.in1_data  = d1;
    bus.out_ready = ordy;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge(v0, d0, v1, d1, ordy);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    logic [WIDTH-1:0] pat [4];
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    bus.in0_valid = 1'b0;
    bus.in0_data  = 8'h00;
    bus.in1_valid = 1'b0;
    bus.in1_data  = 8'h00;
    bus.out_ready = 1'b0;
    sys_rst_n = 1'b1;
    #2 sys_rst_n = 1'b0;
    #1;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_in0_ready", 32'(bus.in0_ready), 32'd1);
    check("rst_in1_ready", 32'(bus.in1_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    sys_rst_n = 1'b1;

    // Fill to full, then a rejected fifth push.
    for (int i = 0; i < 4; i++) cycle(1'b1, pat[i], 1'b0, 8'h00, 1'b0);
    #1;
    check("full_count", 32'(bus.count), 32'd4);
    check("full_in0_ready", 32'(bus.in0_ready), 32'd0);
    cycle(1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
    #1;
    check("reject_count", 32'(bus.count), 32'd4);
    check("head_after_reject", 32'(bus.out_data), 32'h11);

    // Drain from full.
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    #1;
    check("drained_valid", 32'(bus.out_valid), 32'd0);
    check("drained_count", 32'(bus.count), 32'd0);

    // Dual pushes.
    cycle(1'b1, 8'hA1, 1'b1, 8'hA2, 1'b0);
    cycle(1'b1, 8'hA3, 1'b1, 8'hA4, 1'b0);
    #1;
    check("dual_count", 32'(bus.count), 32'd4);
    check("dual_in1_ready", 32'(bus.in1_ready), 32'd0);
    drain();

    // count=3 with dual offer and simultaneous pop; lane 1 retried.
    for (int i = 0; i < 3; i++) cycle(1'b1, pat[i], 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h66, 1'b1, 8'h77, 1'b1);
    #1;
    check("c3_count", 32'(bus.count), 32'd3);
    cycle(1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
    #1;
    check("c3_retry_count", 32'(bus.count), 32'd4);
    drain();

    // Lane 1 alone is ignored.
    cycle(1'b0, 8'h00, 1'b1, 8'h99, 1'b0);
    #1;
    check("in1_only_count", 32'(bus.count), 32'd0);

    // Asynchronous reset mid-stream with two entries held.
    cycle(1'b1, 8'hB1, 1'b1, 8'hB2, 1'b0);
    @(negedge clk);
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    bus.out_ready = 1'b0;
    #2 sys_rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(bus.count), 32'd0);
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    mq.delete();
    @(negedge clk);
    sys_rst_n = 1'b1;

`ifdef ISSUE_QUEUE_2WRITER_BYPASS_EN
    @(negedge clk);
    bus.in0_valid = 1'b1;
    bus.in0_data  = 8'h5A;
    bus.in1_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("byp_valid", 32'(bus.out_valid), 32'd1);
    check("byp_data", 32'(bus.out_data), 32'h5A);
    @(posedge clk);
    model_edge(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
    #1;
    check("byp_count", 32'(bus.count), 32'd0);
`endif

    // Wrap: 3 dual pushes then 6 pops, four rounds.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++)
        cycle(1'b1, WIDTH'($urandom), 1'b1, WIDTH'($urandom), 1'b0);
      for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), WIDTH'($urandom),
            1'($urandom_range(0, 1)), WIDTH'($urandom),
            1'($urandom_range(0, 2) != 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
